// File: rtl/eq_mac_sched.sv
// eq_mac_sched: time-shares one multiplier/accumulator across five EQ bands plus volume for both channels.
// Define EQ_CLIP_DET_EN to add a sticky clip output that flags accumulator saturation.
module eq_mac_sched #(
  parameter int AUD_W      = 16,
  parameter int POT_W      = 12,
  parameter int GAIN_SHIFT = 11,
  parameter int VOL_SHIFT  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic signed [AUD_W-1:0] band_data,
  input  logic        [POT_W-1:0] pot_data,
  output logic        [2:0]       band_sel,
  output logic                    chan_sel,
  output logic                    busy,
  output logic signed [AUD_W-1:0] aud_out_lft,
  output logic signed [AUD_W-1:0] aud_out_rght,
`ifdef EQ_CLIP_DET_EN
  output logic                    clip,
`endif
  output logic                    done
);
  localparam int PW    = AUD_W + POT_W + 1;
  localparam int ACC_W = 21;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-AUD_W+1){1'b0}}, {(AUD_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-AUD_W+1){1'b1}}, {(AUD_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, ACC, VMUL, VST} state_t;

  state_t                  state, state_nxt;
  logic signed [PW-1:0]    prod, vprod;
  logic signed [ACC_W-1:0] acc;
  logic signed [AUD_W-1:0] sat, shadow, res;
  logic signed [POT_W:0]   pot_s;
  logic                    clamp;

  assign pot_s = $signed({1'b0, pot_data});
  assign clamp = acc > ACC_MAX || acc < ACC_MIN;
  assign sat   = acc > ACC_MAX ? {1'b0, {(AUD_W-1){1'b1}}} :
                 acc < ACC_MIN ? {1'b1, {(AUD_W-1){1'b0}}} : acc[AUD_W-1:0];
  // Arithmetic shift floors; the volume product of a saturated sample always fits AUD_W.
  assign res   = AUD_W'(vprod >>> VOL_SHIFT);
  assign busy  = state != IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = vld ? MUL : IDLE;
      MUL:     state_nxt = ACC;
      ACC:     state_nxt = band_sel < 3'd4 ? MUL : VMUL;
      VMUL:    state_nxt = VST;
      VST:     state_nxt = chan_sel ? IDLE : MUL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      band_sel     <= '0;
      chan_sel     <= 1'b0;
      done         <= 1'b0;
      acc          <= '0;
      prod         <= '0;
      vprod        <= '0;
      shadow       <= '0;
      aud_out_lft  <= '0;
      aud_out_rght <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (vld) begin
          band_sel <= '0;
          chan_sel <= 1'b0;
          acc      <= '0;
        end
        MUL: prod <= PW'(band_data) * PW'(pot_s);
        ACC: begin
          acc      <= acc + ACC_W'(prod >>> GAIN_SHIFT);
          band_sel <= band_sel < 3'd4 ? band_sel + 3'd1 : 3'd5;
        end
        VMUL: vprod <= PW'(sat) * PW'(pot_s);
        VST: begin
          band_sel <= '0;
          if (!chan_sel) begin
            shadow   <= res;
            chan_sel <= 1'b1;
            acc      <= '0;
          end else begin
            aud_out_lft  <= shadow;
            aud_out_rght <= res;
            done         <= 1'b1;
            chan_sel     <= 1'b0;
          end
        end
        default: ;
      endcase
    end

`ifdef EQ_CLIP_DET_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) clip <= 1'b0;
    else if (state == VMUL && clamp) clip <= 1'b1;
`else
  logic unused_clamp;
  assign unused_clamp = clamp;
`endif
endmodule

// File: tb/tb_eq_mac_sched.sv
// tb_eq_mac_sched: vector table plus hand sequences (overrun, mid-sequence reset) for eq_mac_sched.
module tb_eq_mac_sched;
  logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
  logic signed [15:0] band_data, aud_out_lft, aud_out_rght;
  logic        [11:0] pot_data;
  logic        [2:0]  band_sel;
  logic               chan_sel, busy, done;
`ifdef EQ_CLIP_DET_EN
  logic               clip;
`endif

  typedef struct packed {
    logic [5:0][11:0]   pot;
    logic [4:0][15:0]   l;
    logic [4:0][15:0]   r;
    logic signed [15:0] el;
    logic signed [15:0] er;
    logic               sat;
  } vec_t;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } exp_t;

  vec_t vec[6];
  vec_t cur;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic signed [15:0] last_l = 0, last_r = 0;
  logic exp_clip = 1'b0;

  always #5 clk = ~clk;

  // External band/pot mux model
  assign band_data = band_sel < 3'd5 ? $signed(chan_sel ? cur.r[band_sel] : cur.l[band_sel]) : 16'sd0;
  assign pot_data  = band_sel < 3'd6 ? cur.pot[band_sel] : 12'd0;

  eq_mac_sched dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .band_data(band_data), .pot_data(pot_data),
    .band_sel(band_sel), .chan_sel(chan_sel), .busy(busy),
    .aud_out_lft(aud_out_lft), .aud_out_rght(aud_out_rght),
`ifdef EQ_CLIP_DET_EN
    .clip(clip),
`endif
    .done(done)
  );

  task automatic chk(input string nm, input logic signed [31:0] a, input logic signed [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic vec_t mk(int p, int pv, int lv, int rv, int el, int er, bit s);
    vec_t v;
    for (int b = 0; b < 5; b++) begin
      v.pot[b] = p[11:0];
      v.l[b]   = lv[15:0];
      v.r[b]   = rv[15:0];
    end
    v.pot[5] = pv[11:0];
    v.el     = el[15:0];
    v.er     = er[15:0];
    v.sat    = s;
    return v;
  endfunction

  task automatic chk_clip();
`ifdef EQ_CLIP_DET_EN
    chk("clip", clip, exp_clip);
`endif
  endtask

  // Runs one sample; ovr >= 0 pulses a second vld that many cycles into the sequence.
  task automatic run_vec(input int i, input int ovr);
    int n, bc, extra, eb;
    bit stable;
    exp_t e;
    @(negedge clk);
    cur = vec[i];
    vld = 1'b1;
    sb.push_back('{vec[i].el, vec[i].er});
    @(negedge clk);
    vld = 1'b0;
    n = 0; bc = 0; stable = 1'b1;
    while (!done && n < 40) begin
      if (busy) bc++;
      if (aud_out_lft !== last_l || aud_out_rght !== last_r) stable = 1'b0;
      if (n < 24) begin
        eb = (n % 12) < 10 ? (n % 12) / 2 : 5;
        chk($sformatf("band_sel[%0d]", n), band_sel, eb);
        chk($sformatf("chan_sel[%0d]", n), chan_sel, n >= 12);
      end
      vld = (n == ovr);
      @(negedge clk);
      n++;
    end
    vld = 1'b0;
    chk("latency", n, 24);
    chk("busy_cycles", bc, 24);
    chk("hold_between_done", stable, 1);
    chk("busy_at_done", busy, 0);
    chk("done", done, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("aud_out_lft[v%0d]", i), aud_out_lft, e.l);
      chk($sformatf("aud_out_rght[v%0d]", i), aud_out_rght, e.r);
      last_l = e.l;
      last_r = e.r;
    end
    exp_clip = exp_clip | vec[i].sat;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("sel_idle", {chan_sel, band_sel}, 0);
    chk_clip();
    if (ovr >= 0) begin
      extra = 0;
      repeat (30) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("overrun_extra_done", extra, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pp[5] = '{2048, 1024, 0, 4095, 512};
    vec[0] = mk(2048, 4095, 1000, 1000, 4998, 4998, 1'b0);
    vec[1] = mk(0, 4095, 1000, -1234, 0, 0, 1'b0);
    vec[2] = mk(2048, 0, 1000, -1234, 0, 0, 1'b0);
    vec[3] = mk(0, 2048, 0, 0, 562, -563, 1'b0);
    for (int b = 0; b < 5; b++) begin
      vec[3].pot[b] = pp[b][11:0];
      vec[3].l[b]   = 16'(100 * (b + 1));
      vec[3].r[b]   = 16'(-100 * (b + 1));
    end
    vec[4] = mk(4095, 4095, 30000, -30000, 32759, -32760, 1'b1);
    vec[5] = mk(2048, 4095, -1, 32767, -5, 32759, 1'b1);
    cur = vec[0];
    repeat (3) @(negedge clk);
    chk("rst_band_sel", band_sel, 0);
    chk("rst_chan_sel", chan_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lft", aud_out_lft, 0);
    chk("rst_rght", aud_out_rght, 0);
    chk_clip();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(i, -1);
    run_vec(0, 5);
    @(negedge clk);
    cur = vec[3];
    vld = 1'b1;
    sb.push_back('{vec[3].el, vec[3].er});
    @(negedge clk);
    vld = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_lft", aud_out_lft, 0);
    chk("midrst_rght", aud_out_rght, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sel", {chan_sel, band_sel}, 0);
    sb.delete();
    last_l = 0;
    last_r = 0;
    exp_clip = 1'b0;
    chk_clip();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(3, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eq_mac_sched.md
Name: eq_mac_sched

Overview:
- Scheduler that time-shares one signed multiplier and one accumulator across the five EQ band gains and the volume stage, for both audio channels.
- Each sample-valid pulse from the I2S slave starts one sequence.
- The block steers an external band/pot mux through band_sel/chan_sel and presents final equalized samples to the speaker driver with a done strobe.
- Replaces the per-band multipliers of the EQ datapath.

Parameters:
- AUD_W, 16, width of signed band samples and outputs.
- POT_W, 12, width of unsigned pot values.
- GAIN_SHIFT, 11, arithmetic right shift applied to each band product; pot 2048 = unity gain.
- VOL_SHIFT, 12, arithmetic right shift applied to the volume product.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset.
- vld  in  1  one-cycle pulse: new left/right samples are available in the band filters.
- band_data  in  AUD_W  signed band-filter output selected by band_sel/chan_sel; combinational from the external mux.
- pot_data  in  POT_W  unsigned pot selected by band_sel (0 LP, 1 B1, 2 B2, 3 B3, 4 HP, 5 VOLUME).
- band_sel  out  3  mux select for band_data/pot_data.
- chan_sel  out  1  0 = left, 1 = right.
- busy  out  1  high while a sequence is in progress.
- aud_out_lft  out  AUD_W  equalized left sample (signed).
- aud_out_rght  out  AUD_W  equalized right sample (signed).
- done  out  1  one-cycle strobe: outputs were just updated.

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clock is clk.
- Reset values: state IDLE; band_sel=0, chan_sel=0, busy=0, done=0, aud_out_lft=0, aud_out_rght=0; accumulator, product register and left shadow register all 0.
- Reset mid-sequence: asserting rst_n at any time aborts the sequence immediately. No partial output update is made.
- States: IDLE, MUL, ACC, VMUL, VST.
- IDLE:
  - vld sampled high at edge E0 -> MUL, chan_sel=0, band_sel=0, acc=0, busy=1.
  - vld low -> remain in IDLE.
- MUL (one edge): prod <= band_data * $signed({1'b0,pot_data}), a 29-bit signed product. Next state is ACC.
- ACC (one edge):
  - acc <= acc + (prod >>> GAIN_SHIFT), using a 21-bit signed accumulator.
  - If band_sel<4: band_sel++ and go to MUL.
  - Otherwise: band_sel=5 and go to VMUL.
- VMUL (one edge):
  - Saturate acc to AUD_W signed, clamping to [-32768, 32767].
  - vprod <= sat * $signed({1'b0,pot_data}); pot_data carries VOLUME while band_sel=5.
  - Next state is VST.
- VST (one edge): res = vprod >>> VOL_SHIFT. This shift rounds toward negative infinity and never overflows AUD_W.
  - chan_sel=0: store res in the left shadow register; chan_sel=1, band_sel=0, acc=0; go to MUL.
  - chan_sel=1: aud_out_lft<=shadow and aud_out_rght<=res on the same edge; done=1 for the following cycle; busy=0, band_sel=0, chan_sel=0; go to IDLE.
- Latency:
  - Each channel takes 12 edges (5 bands x 2 edges, plus VMUL and VST).
  - Outputs update at edge E0+24; done is high during the cycle after E0+24.
  - The next vld is accepted at the edge after done.
- Output stability: aud_out_* hold their values between done strobes. Left and right outputs never update on different edges.
- vld while busy: ignored. No restart, no queueing, no effect on the current results.
- band_data/pot_data are sampled only on MUL and VMUL edges. They are don't-care at all other times.

Optional Feature:
- Macro: EQ_CLIP_DET_EN.
- When defined:
  - Output port clip (1 bit, reset 0) is added.
  - clip is set on any VMUL edge where the accumulator saturation actually clamps.
  - clip stays set (sticky) until reset.
  - clip is intended to drive an LED.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Unity gain: all pots=2048, VOLUME=4095, band_data=1000 for every band/channel, one vld -> done exactly 24 clocks after the vld edge; aud_out_lft=aud_out_rght=4998; busy high for 24 cycles.
- Saturation:
  - All pots=4095, VOLUME=4095, left bands=+30000, right bands=-30000 -> lft=32759, rght=-32760.
  - With EQ_CLIP_DET_EN defined, clip=1 after the sequence and remains 1 through a following unclipped sample.
- Mute paths:
  - Band pots all 0 with VOLUME=4095 -> both outputs 0.
  - Band pots 2048 with VOLUME=0 -> both outputs 0.
- Overrun: a second vld pulse 5 cycles after the first -> exactly one done, 24 clocks after the first vld, with the first sample's values; the band_sel sequence is unchanged.
- Mid-sequence reset: assert rst_n low at cycle 10 of a sequence -> outputs, done and busy go 0 asynchronously; a fresh vld then completes normally in 24 clocks.
- Select sequencing: monitor band_sel/chan_sel after vld -> band_sel follows 0,0,1,1,2,2,3,3,4,4,5,5 with chan_sel=0, then the same pattern with chan_sel=1, then returns to 0/0.
